// File: rtl/demo_bus_pkg.sv
// rtl/demo_bus_pkg.sv - shared encodings for the demo bus slave
package demo_bus_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [31:0] MISS_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/demo_bus_mem.sv
// rtl/demo_bus_mem.sv - single-port synchronous word store, registered read
module demo_bus_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/demo_bus_slave.sv
// rtl/demo_bus_slave.sv - wait-stated bus slave over a local word store
module demo_bus_slave
  import demo_bus_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [15:0] BASE_ADR    = 16'h0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  op,
  input  logic [15:0] adr,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic        data_oe,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  state_e        state, state_nxt;
  logic [3:0]    cnt;
  op_e           op_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          hit_q;

  logic [16:0]   adr_off;
  logic          hit_in;
  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  // An address below BASE_ADR wraps into bit 16 and therefore fails the compare.
  assign adr_off = {1'b0, adr} - {1'b0, BASE_ADR};
  assign hit_in  = adr_off < 17'(DEPTH);
  assign accept  = (state == ST_IDLE) && ((op == OP_READ) || (op == OP_WRITE));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      op_q    <= OP_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= 4'(WAIT_STATES);
      op_q    <= op_e'(op);
      idx_q   <= adr_off[AW-1:0];
      wdata_q <= data_write;
      hit_q   <= hit_in;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Reading the live address in IDLE lets a zero-wait read have its word ready in RESP.
  assign mem_addr = (state == ST_IDLE) ? adr_off[AW-1:0] : idx_q;
  assign mem_we   = (state == ST_RESP) && (op_q == OP_WRITE) && hit_q;

  demo_bus_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Response flops load on the edge that ends RESP, giving the ready cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready     <= 1'b0;
      err       <= 1'b0;
      data_oe   <= 1'b0;
      data_read <= '0;
    end else begin
      ready     <= (state == ST_RESP);
      err       <= (state == ST_RESP) && !hit_q;
      data_oe   <= (state == ST_RESP) && (op_q == OP_READ);
      data_read <= ((state == ST_RESP) && (op_q == OP_READ))
                   ? (hit_q ? mem_rdata : MISS_DATA) : 32'h0;
    end
  end

endmodule

// File: tb/tb_demo_bus_slave.sv
// tb/tb_demo_bus_slave.sv - randomized model-checked bench for demo_bus_slave
module tb_demo_bus_slave;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  op [3];
  logic [15:0] adr [3];
  logic [31:0] dw [3];
  logic [31:0] dr [3];
  logic        oe [3];
  logic        rdy [3];
  logic        er [3];

  logic [31:0] mem_m [3][256];
  bit          vld [3][256];
  int          total = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  demo_bus_slave #(.DEPTH(256), .BASE_ADR(16'h0000), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset_n(reset_n), .op(op[0]), .adr(adr[0]), .data_write(dw[0]),
    .data_read(dr[0]), .data_oe(oe[0]), .ready(rdy[0]), .err(er[0]));
  demo_bus_slave #(.DEPTH(256), .BASE_ADR(16'h0000), .WAIT_STATES(1)) u_ws1 (
    .clock(clock), .reset_n(reset_n), .op(op[1]), .adr(adr[1]), .data_write(dw[1]),
    .data_read(dr[1]), .data_oe(oe[1]), .ready(rdy[1]), .err(er[1]));
  demo_bus_slave #(.DEPTH(256), .BASE_ADR(16'h0000), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset_n(reset_n), .op(op[2]), .adr(adr[2]), .data_write(dw[2]),
    .data_read(dr[2]), .data_oe(oe[2]), .ready(rdy[2]), .err(er[2]));

  function automatic int ws(int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s k%0d ready", tag, k), rdy[k], 0);
      chk($sformatf("%s k%0d err", tag, k), er[k], 0);
      chk($sformatf("%s k%0d oe", tag, k), oe[k], 0);
      chk($sformatf("%s k%0d rdata", tag, k), dr[k], 0);
    end
  endtask

  // One transfer: ready must appear exactly WS+1 cycles after the accepting edge.
  task automatic xfer(int k, logic [1:0] o, logic [15:0] a, logic [31:0] d, bit scramble);
    int          w;
    bit          hit;
    bit          is_rd;
    logic [31:0] exp_rd;
    w     = ws(k);
    hit   = (a < 16'd256);
    is_rd = (o == 2'b01);
    @(negedge clock);
    op[k] = o; adr[k] = a; dw[k] = d;
    @(posedge clock);
    for (int i = 0; i <= w + 2; i++) begin
      @(negedge clock);
      if (i == 0) begin
        op[k] = scramble ? 2'b11 : 2'b00;
        if (scramble) begin
          adr[k] = 16'($urandom);
          dw[k]  = $urandom;
        end
      end
      chk($sformatf("k%0d a%h ready@%0d", k, a, i), rdy[k], 32'(i == w + 1));
      if (i == w + 1) begin
        chk($sformatf("k%0d a%h err", k, a), er[k], 32'(!hit));
        chk($sformatf("k%0d a%h oe", k, a), oe[k], 32'(is_rd));
        exp_rd = !is_rd ? 32'h0 : (hit ? mem_m[k][a[7:0]] : 32'hDEAD_BEEF);
        if (!(is_rd && hit && !vld[k][a[7:0]]))
          chk($sformatf("k%0d a%h rdata", k, a), dr[k], exp_rd);
      end else begin
        chk($sformatf("k%0d a%h oe@%0d", k, a, i), oe[k], 0);
        chk($sformatf("k%0d a%h rdata@%0d", k, a, i), dr[k], 0);
      end
    end
    if (!is_rd && hit) begin
      mem_m[k][a[7:0]] = d;
      vld[k][a[7:0]]   = 1'b1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      op[k] = 2'b00; adr[k] = '0; dw[k] = '0;
    end
    #1;
    chk_quiet("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk_quiet($sformatf("idle%0d", c));
    end

    // Write then read back with one wait state; miss read and discarded miss write.
    xfer(1, 2'b10, 16'h0010, 32'h1234_5678, 1'b0);
    xfer(1, 2'b01, 16'h0010, 32'h0, 1'b0);
    chk("model 0x10", mem_m[1][8'h10], 32'h1234_5678);
    xfer(1, 2'b01, 16'h0100, 32'h0, 1'b0);
    xfer(1, 2'b10, 16'h0100, 32'h5555_AAAA, 1'b0);

    // Zero wait states, op held through ready: second write starts from the IDLE cycle.
    @(negedge clock);
    op[0] = 2'b10; adr[0] = 16'h0001; dw[0] = 32'h0101_0101;
    @(posedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) begin adr[0] = 16'h0002; dw[0] = 32'h0202_0202; end
      if (i == 2) op[0] = 2'b00;
      chk($sformatf("b2b ready@%0d", i), rdy[0], 32'((i == 1) || (i == 3)));
    end
    mem_m[0][1] = 32'h0101_0101; vld[0][1] = 1'b1;
    mem_m[0][2] = 32'h0202_0202; vld[0][2] = 1'b1;
    xfer(0, 2'b01, 16'h0001, 32'h0, 1'b0);
    xfer(0, 2'b01, 16'h0002, 32'h0, 1'b0);

    // Address moved during WAIT must not redirect the write.
    xfer(2, 2'b10, 16'h0004, 32'h0000_0044, 1'b0);
    @(negedge clock);
    op[2] = 2'b10; adr[2] = 16'h0003; dw[2] = 32'hA5A5_A5A5;
    @(posedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) op[2] = 2'b00;
      if (i == 1) adr[2] = 16'h0004;
    end
    mem_m[2][3] = 32'hA5A5_A5A5; vld[2][3] = 1'b1;
    xfer(2, 2'b01, 16'h0003, 32'h0, 1'b0);
    xfer(2, 2'b01, 16'h0004, 32'h0, 1'b0);

    // Reset during WAIT of a write; the parallel read shows the outputs clear without an edge.
    xfer(2, 2'b10, 16'h0005, 32'h0, 1'b0);
    xfer(1, 2'b10, 16'h0007, 32'hCAFE_0007, 1'b0);
    @(negedge clock);
    op[2] = 2'b10; adr[2] = 16'h0005; dw[2] = 32'hFFFF_FFFF;
    op[1] = 2'b01; adr[1] = 16'h0007;
    @(posedge clock);
    @(negedge clock);
    op[2] = 2'b00; op[1] = 2'b00;
    @(negedge clock);
    @(negedge clock);
    chk("pre-reset ready", rdy[1], 1);
    chk("pre-reset rdata", dr[1], 32'hCAFE_0007);
    #1 reset_n = 1'b0;
    #1;
    chk_quiet("async reset");
    @(negedge clock);
    reset_n = 1'b1;
    xfer(2, 2'b01, 16'h0005, 32'h0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        logic [1:0]  o;
        logic [15:0] a;
        o = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h0100, 16'hFFFF))
                                        : 16'($urandom_range(0, 31));
        xfer(k, o, a, $urandom, 1'b1);
      end
    end

    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 256; j++)
        if (vld[k][j]) xfer(k, 2'b01, 16'(j), 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demo_bus_slave.md
DEMO_BUS_SLAVE -- requirements
Module: demo_bus_slave

Interface
REQ-001 Parameter DEPTH, default 256, SHALL be the number of 32-bit words of backing store (power of two, 16..4096).
REQ-002 Parameter BASE_ADR, default 16'h0000, SHALL be the first word address decoded by this slave (aligned to DEPTH).
REQ-003 Parameter WAIT_STATES, default 1, SHALL be the number of wait cycles inserted before each response (0..15).
REQ-004 clock  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 op  in  2  SHALL be the bus operation: 2'b00 IDLE, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved.
REQ-007 adr  in  16  SHALL be the word address of the transfer.
REQ-008 data_write  in  32  SHALL be the write data from the master.
REQ-009 data_read  out  32  SHALL be the read data returned to the master.
REQ-010 data_oe  out  1  SHALL be high only while data_read carries valid read data.
REQ-011 ready  out  1  SHALL be a one-cycle pulse marking transfer completion.
REQ-012 err  out  1  SHALL be high together with ready when the transfer address missed the decode range.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 In IDLE, an edge with op READ or WRITE SHALL accept the transfer, capture op, adr and data_write into internal registers, and move to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-015 op 2'b11 or IDLE in state IDLE SHALL be ignored; the FSM stays in IDLE and outputs stay low.
REQ-016 In WAIT, a 4-bit counter loaded with WAIT_STATES at acceptance SHALL decrement each cycle; at count 1 the FSM moves to RESP.
REQ-017 Latency: with acceptance at edge N, ready SHALL be high for exactly the cycle between edges N+1+WAIT_STATES and N+2+WAIT_STATES.
REQ-018 Changes on op, adr or data_write after acceptance SHALL have no effect on the transfer in flight.
REQ-019 A hit SHALL be BASE_ADR <= adr < BASE_ADR+DEPTH; word index SHALL be adr-BASE_ADR truncated to log2(DEPTH) bits.
REQ-020 READ hit: data_read SHALL equal the stored word and data_oe SHALL be 1 during the RESP cycle.
REQ-021 WRITE hit: the captured data SHALL be committed to the store on the edge that ends RESP; data_oe SHALL stay 0.
REQ-022 Miss: ready and err SHALL both be 1 in RESP, a read SHALL return 32'hDEAD_BEEF with data_oe=1, and a write SHALL be discarded.
REQ-023 RESP SHALL always return to IDLE, so at least one IDLE cycle separates transfers; op held after ready SHALL start a new transfer from that IDLE cycle.
REQ-024 Outside RESP, data_read SHALL be 32'h0 and data_oe, ready and err SHALL be 0.
REQ-025 A read of a word written by the immediately preceding transfer SHALL return the new value.

Reset
REQ-026 reset_n low SHALL force state IDLE, counter 0, captured registers 0, and data_read=0, data_oe=0, ready=0, err=0 immediately, with no clock edge required.
REQ-027 Reset asserted mid-transfer SHALL abort it; a pending write SHALL NOT reach the store.
REQ-028 Store contents SHALL NOT be reset; they are undefined until written.

Structure
REQ-029 Package demo_bus_pkg SHALL hold the op encoding enum, the FSM state enum and the miss-data constant 32'hDEAD_BEEF.
REQ-030 The backing store SHALL be the sub-module demo_bus_mem: single-port synchronous RAM, DEPTH x 32, one write enable.

Verification
REQ-031 Reset release, op=IDLE for 10 cycles -> ready, err, data_oe remain 0.
REQ-032 WAIT_STATES=1: WRITE adr 16'h0010 data 32'h1234_5678, then READ 16'h0010 -> ready high 2 cycles after each acceptance, read returns 32'h1234_5678 with data_oe=1, err=0.
REQ-033 READ adr 16'h0100 with DEPTH=256 -> ready=1, err=1, data_read=32'hDEAD_BEEF; a following WRITE to 16'h0100 leaves words 0..255 unchanged.
REQ-034 WAIT_STATES=0: back-to-back WRITEs to 16'h0001 and 16'h0002 with op held -> ready pulses 2 cycles apart, both words stored.
REQ-035 Change adr from 16'h0003 to 16'h0004 during WAIT (WAIT_STATES=3) of a WRITE of 32'hA5A5_A5A5 -> only word 3 is updated.
REQ-036 Assert reset_n low during WAIT of a WRITE of 32'hFFFF_FFFF to 16'h0005, after writing 32'h0 there -> outputs clear immediately; a later read of 16'h0005 returns 32'h0.
